can_rx_destuff: RTL and testbench
=================================

// Module: can_rx_destuff
// PURPOSE
//  Bit de-stuffer for the CAN receive path. Sits directly downstream of can_rx_sample
//  and consumes its sampled bit stream (dout/dvalid). Removes the stuff bit inserted
//  after every STUFF_LEN consecutive identical bits, and flags a stuff error on
//  STUFF_LEN+1 identical bits. Forwards de-stuffed bits to the frame decoder, which
//  drives stuff_en low from the CRC delimiter onward (fixed-form fields).
// PARAMETERS
//  STUFF_LEN  5  identical-bit run length that forces a stuff bit (CAN 2.0: 5)
// PORTS
//  clk        in   1  system clock (100 MHz)
//  rst_n      in   1  synchronous active-low reset, sampled on rising clk
//  en         in   1  frame active; high from SOF until end of frame / error recovery
//  stuff_en   in   1  1 = de-stuffing and stuff checking active; 0 = pass-through
//  din        in   1  sampled bit from can_rx_sample (dout)
//  din_valid  in   1  one-cycle strobe, din valid (can_rx_sample dvalid)
//  dout       out  1  de-stuffed data bit
//  dvalid     out  1  one-cycle strobe, dout valid
//  stuff_bit  out  1  one-cycle pulse: a stuff bit was removed
//  stuff_err  out  1  sticky stuff error, held until en low or reset
// BEHAVIOUR
//  - Reset (rst_n low at clk edge): state IDLE; dout=0, dvalid=0, stuff_bit=0,
//    stuff_err=0, run_cnt=0, last_bit=1 (recessive). Reset mid-frame aborts at once.
//  - States: IDLE, RUN, ERROR. run_cnt width = $clog2(STUFF_LEN+1).
//  - IDLE: en=1 -> RUN (same cycle as a din_valid: that bit is processed as RUN).
//  - RUN, on din_valid (the first bit after entering RUN is SOF; run_cnt=0 -> counts 1):
//    * stuff_en=1 and run_cnt==STUFF_LEN: bit is a stuff bit.
//      din!=last_bit -> drop (no dvalid), stuff_bit=1, last_bit=din, run_cnt=1.
//      din==last_bit -> stuff_err=1, no dvalid, -> ERROR.
//    * otherwise: dout=din, dvalid=1; din==last_bit ? run_cnt+1 : run_cnt=1; last_bit=din.
//    * stuff_en=0: bit always forwarded; run_cnt saturates at STUFF_LEN (never wraps),
//      no stuff_bit, no stuff_err.
//  - A removed stuff bit counts as bit 1 of the next run (CAN rule).
//  - stuff_en is sampled in the same cycle as din_valid; changes between strobes
//    take effect on the next strobe.
//  - Latency: dout/dvalid/stuff_bit/stuff_err registered, 1 clk after din_valid.
//    dvalid and stuff_bit are never high together; both are 1-clk pulses.
//  - ERROR: din_valid ignored; stuff_err held 1; dvalid=0. en=0 -> IDLE.
//  - en=0 in any state: -> IDLE next clk, run_cnt=0, last_bit=1, stuff_err cleared;
//    a din_valid in that cycle is ignored (no output).
//  - din_valid with en=0 in IDLE: ignored.
// TESTING
//  1. en=1, bits 0,0,0,0,0,1,1 -> dvalid x6: dout 0,0,0,0,0,1; stuff_bit on 6th bit only.
//  2. en=1, six 0s -> 5 dvalid, 6th: stuff_err=1, no dvalid; stays 1 until en=0.
//  3. Stuff-bit run carry: 0,0,0,0,0,1(stuff),1,1,1,1,0(stuff),0 -> dout 0x5,1x4,0;
//     stuff_bit pulses on bits 6 and 11, no error.
//  4. stuff_en=0, seven 1s -> 7 dvalid, dout all 1, stuff_bit/stuff_err stay 0.
//  5. en dropped after 3 zeros, re-raised, then 0,0,0,0,0,1 -> counter restarted:
//     6th bit removed as stuff; no error from earlier zeros.
//  6. rst_n low for 1 clk mid-frame after stuff_err -> next clk all outputs 0, IDLE;
//     din_valid in reset cycle produces no dvalid.

Source files
------------

// File: rtl/can_rx_destuff_if.sv
// can_rx_destuff_if: sampled-bit input stream and de-stuffed output stream of the CAN bit de-stuffer.
interface can_rx_destuff_if;
  logic en;
  logic stuff_en;
  logic din;
  logic din_valid;
  logic dout;
  logic dvalid;
  logic stuff_bit;
  logic stuff_err;
  modport master (output en, stuff_en, din, din_valid, input dout, dvalid, stuff_bit, stuff_err);
  modport slave (input en, stuff_en, din, din_valid, output dout, dvalid, stuff_bit, stuff_err);
endinterface

// File: rtl/can_rx_destuff.sv
// can_rx_destuff: removes CAN stuff bits after STUFF_LEN identical bits and flags stuff errors.
module can_rx_destuff #(
  parameter int STUFF_LEN = 5
) (
  input logic clk,
  input logic rst_n,
  can_rx_destuff_if.slave bus
);
  localparam int CW = $clog2(STUFF_LEN + 1);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN = 2'd1;
  localparam logic [1:0] ERROR = 2'd2;
  logic [1:0] state;
  logic [CW-1:0] run_cnt;
  logic last_bit;
  logic take;
  logic is_stuff;
  logic same;
  logic [CW-1:0] run_next;
  always_comb begin
    take = bus.en && state != ERROR && bus.din_valid;
    is_stuff = bus.stuff_en && run_cnt == CW'(STUFF_LEN);
    same = bus.din == last_bit;
    // saturate so pass-through runs longer than STUFF_LEN never wrap
    run_next = !same ? CW'(1) : run_cnt == CW'(STUFF_LEN) ? run_cnt : run_cnt + CW'(1);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      run_cnt <= '0;
      last_bit <= 1'b1;
      bus.dout <= 1'b0;
      bus.dvalid <= 1'b0;
      bus.stuff_bit <= 1'b0;
      bus.stuff_err <= 1'b0;
    end else begin
      bus.dvalid <= 1'b0;
      bus.stuff_bit <= 1'b0;
      if (!bus.en) begin
        state <= IDLE;
        run_cnt <= '0;
        last_bit <= 1'b1;
        bus.stuff_err <= 1'b0;
      end else begin
        if (state == IDLE) state <= RUN;
        if (take && is_stuff && same) begin
          state <= ERROR;
          bus.stuff_err <= 1'b1;
        end else if (take && is_stuff) begin
          // removed stuff bit opens the next run
          bus.stuff_bit <= 1'b1;
          last_bit <= bus.din;
          run_cnt <= CW'(1);
        end else if (take) begin
          bus.dout <= bus.din;
          bus.dvalid <= 1'b1;
          last_bit <= bus.din;
          run_cnt <= run_next;
        end
      end
    end
  end
endmodule

// File: tb/tb_can_rx_destuff.sv
// tb_can_rx_destuff: randomized scoreboard bench; reference model works on the frame's raw bit history.
module tb_can_rx_destuff;
  typedef struct {
    int kind;
    bit b;
  } ev_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  ev_t sb[$];
  bit hist[$];
  bit model_err = 1'b0;
  bit exp_err = 1'b0;
  can_rx_destuff_if bus ();
  can_rx_destuff #(.STUFF_LEN(5)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  // length of the identical-bit run at the end of the frame so far, capped at 5
  function automatic int tail_run();
    int n = 0;
    for (int i = hist.size() - 1; i >= 0 && hist[i] == hist[hist.size() - 1]; i--) n++;
    return n > 5 ? 5 : n;
  endfunction
  always @(negedge clk) begin
    if (rst_n) begin
      ev_t e;
      if (bus.dvalid && bus.stuff_bit) chk("dvalid_and_stuff_bit", 1, 0);
      if (bus.dvalid) begin
        if (sb.size() == 0) chk("unexpected_dvalid", 1, 0);
        else begin
          e = sb.pop_front();
          chk("dvalid_kind", 0, e.kind);
          chk("dout", int'(bus.dout), int'(e.b));
        end
      end
      if (bus.stuff_bit) begin
        if (sb.size() == 0) chk("unexpected_stuff_bit", 1, 0);
        else begin
          e = sb.pop_front();
          chk("stuff_bit_kind", 1, e.kind);
        end
      end
      chk("stuff_err", int'(bus.stuff_err), int'(exp_err));
    end
  end
  task automatic send(input bit b, input bit se);
    bit last;
    int run;
    bit err_now = 1'b0;
    bus.din = b;
    bus.stuff_en = se;
    bus.din_valid = 1'b1;
    if (!model_err) begin
      run = tail_run();
      last = hist.size() ? hist[hist.size() - 1] : 1'b1;
      if (se && run == 5) begin
        if (b != last) begin
          sb.push_back('{1, b});
          hist.push_back(b);
        end else err_now = 1'b1;
      end else begin
        sb.push_back('{0, b});
        hist.push_back(b);
      end
    end
    @(posedge clk);
    #1;
    bus.din_valid = 1'b0;
    if (err_now) begin
      model_err = 1'b1;
      exp_err = 1'b1;
    end
    @(negedge clk);
    #1;
  endtask
  task automatic send_seq(input bit bits[$], input bit se);
    foreach (bits[i]) send(bits[i], se);
  endtask
  task automatic drop_en(input bit with_valid);
    bus.en = 1'b0;
    bus.din = 1'b0;
    bus.din_valid = with_valid;
    @(posedge clk);
    #1;
    bus.din_valid = 1'b0;
    bus.en = 1'b1;
    hist.delete();
    model_err = 1'b0;
    exp_err = 1'b0;
    @(negedge clk);
    #1;
  endtask
  task automatic pulse_reset();
    rst_n = 1'b0;
    bus.din = 1'b0;
    bus.din_valid = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.din_valid = 1'b0;
    hist.delete();
    model_err = 1'b0;
    exp_err = 1'b0;
    chk("rst_dout", int'(bus.dout), 0);
    chk("rst_dvalid", int'(bus.dvalid), 0);
    chk("rst_stuff_bit", int'(bus.stuff_bit), 0);
    chk("rst_stuff_err", int'(bus.stuff_err), 0);
    @(negedge clk);
    #1;
  endtask
  initial begin
    bit cur;
    bit se;
    bus.en = 1'b0;
    bus.stuff_en = 1'b1;
    bus.din = 1'b0;
    bus.din_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("init_dout", int'(bus.dout), 0);
    chk("init_dvalid", int'(bus.dvalid), 0);
    chk("init_stuff_bit", int'(bus.stuff_bit), 0);
    chk("init_stuff_err", int'(bus.stuff_err), 0);
    rst_n = 1'b1;
    bus.din_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.din_valid = 1'b0;
    chk("idle_en_low_ignored", int'(bus.dvalid), 0);
    bus.en = 1'b1;
    send_seq('{0, 0, 0, 0, 0, 1, 1}, 1'b1);
    drop_en(1'b0);
    send_seq('{0, 0, 0, 0, 0, 0, 0, 1}, 1'b1);
    drop_en(1'b1);
    send_seq('{0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 0, 0}, 1'b1);
    drop_en(1'b0);
    send_seq('{1, 1, 1, 1, 1, 1, 1}, 1'b0);
    send(1'b0, 1'b1);
    drop_en(1'b0);
    send_seq('{0, 0, 0}, 1'b1);
    drop_en(1'b1);
    send_seq('{0, 0, 0, 0, 0, 1}, 1'b1);
    drop_en(1'b0);
    send_seq('{0, 0, 0, 0, 0, 0}, 1'b1);
    pulse_reset();
    send_seq('{0, 1, 1, 1, 1, 1, 0}, 1'b1);
    drop_en(1'b0);
    for (int f = 0; f < 60; f++) begin
      int len = $urandom_range(8, 40);
      cur = 1'b0;
      for (int i = 0; i < len; i++) begin
        se = $urandom_range(0, 9) != 0;
        send(cur, se);
        if ($urandom_range(0, 2) == 0) cur = ~cur;
        repeat ($urandom_range(0, 2)) @(negedge clk);
        if ($urandom_range(0, 99) == 0) pulse_reset();
      end
      drop_en($urandom_range(0, 1) == 1);
    end
    repeat (2) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
